// File: rtl/rob_pkg.sv
// Shared encodings and sizing for the reorder buffer.
// The optional ROB_QUERY_BYPASS_EN build lets operand lookups see the CDB in the same cycle.
package rob_pkg;

  localparam int ROB_WIDTH_DEFAULT = 4;
  localparam int ROB_TAG_W         = ROB_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    ROB_REG    = 2'b00,
    ROB_STORE  = 2'b01,
    ROB_BRANCH = 2'b10,
    ROB_JUMP   = 2'b11
  } rob_type_e;

  // REG and JUMP retirees write rd, except that x0 is never written.
  function automatic logic writesReg(input rob_type_e t, input logic [4:0] rd);
    return ((t == ROB_REG) || (t == ROB_JUMP)) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags, captures CDB results, answers lookups, retires in order.
// Define ROB_QUERY_BYPASS_EN to let operand lookups forward a same-cycle CDB broadcast.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dispatch_valid,
  input  logic [1:0]           dispatch_type,
  input  logic [4:0]           dispatch_rd,
  input  logic                 dispatch_pred_taken,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] dispatch_tag,
  input  logic                 cdb_active,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_val,
  input  logic [31:0]          cdb_addr,
  input  logic [ROB_WIDTH-1:0] query1_tag,
  input  logic [ROB_WIDTH-1:0] query2_tag,
  output logic                 query1_ready,
  output logic                 query2_ready,
  output logic [31:0]          query1_val,
  output logic [31:0]          query2_val,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_val,
  output logic                 commit_reg,
  output logic                 commit_store,
  output logic                 predict_fail,
  output logic [31:0]          fail_addr
);

  localparam int                 DEPTH      = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [DEPTH-1:0] pred_q, pred_d;
  rob_type_e        type_q [DEPTH];
  rob_type_e        type_d [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [31:0]      val_d  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];

  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 commitValid_q, commitValid_d;
  logic [ROB_WIDTH-1:0] commitTag_q, commitTag_d;
  logic [4:0]           commitRd_q, commitRd_d;
  logic [31:0]          commitVal_q, commitVal_d;
  logic                 commitReg_q, commitReg_d;
  logic                 commitStore_q, commitStore_d;
  logic                 predictFail_q, predictFail_d;
  logic [31:0]          failAddr_q, failAddr_d;

  logic accept;
  logic capture;
  logic retire;
  logic mispredict;

  assign rob_full     = (count_q == FULL_COUNT);
  assign dispatch_tag = tail_q;

  assign commit_valid = commitValid_q;
  assign commit_tag   = commitTag_q;
  assign commit_rd    = commitRd_q;
  assign commit_val   = commitVal_q;
  assign commit_reg   = commitReg_q;
  assign commit_store = commitStore_q;
  assign predict_fail = predictFail_q;
  assign fail_addr    = failAddr_q;

  // A same-cycle retire never frees a slot for dispatch: rob_full comes from registered count only.
  assign accept     = rdy_in && dispatch_valid && !rob_full;
  assign capture    = rdy_in && cdb_active && busy_q[cdb_tag];
  assign retire     = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign mispredict = retire && (type_q[head_q] == ROB_BRANCH) &&
                      (val_q[head_q][0] != pred_q[head_q]);

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    pred_d  = pred_q;
    type_d  = type_q;
    rd_d    = rd_q;
    val_d   = val_q;
    addr_d  = addr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (ROB_WIDTH + 1)'(accept) - (ROB_WIDTH + 1)'(retire);

    if (capture) begin
      ready_d[cdb_tag] = 1'b1;
      val_d[cdb_tag]   = cdb_val;
      addr_d[cdb_tag]  = cdb_addr;
    end

    if (accept) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      pred_d[tail_q]  = dispatch_pred_taken;
      type_d[tail_q]  = rob_type_e'(dispatch_type);
      rd_d[tail_q]    = dispatch_rd;
      tail_d          = tail_q + 1'b1;
    end

    if (retire) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    // A mispredict discards everything younger, including this cycle's dispatch and CDB capture.
    if (mispredict) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Retire pulses carry the head entry's fields; every field reads 0 when nothing retires.
  always_comb begin
    commitValid_d = retire;
    commitTag_d   = '0;
    commitRd_d    = '0;
    commitVal_d   = '0;
    commitReg_d   = 1'b0;
    commitStore_d = 1'b0;
    predictFail_d = mispredict;
    failAddr_d    = '0;
    if (retire) begin
      commitTag_d   = head_q;
      commitRd_d    = rd_q[head_q];
      commitVal_d   = val_q[head_q];
      commitReg_d   = writesReg(type_q[head_q], rd_q[head_q]);
      commitStore_d = (type_q[head_q] == ROB_STORE);
    end
    if (mispredict) begin
      failAddr_d = addr_q[head_q];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      pred_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= ROB_REG;
        rd_q[i]   <= '0;
        val_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitValid_q <= 1'b0;
      commitTag_q   <= '0;
      commitRd_q    <= '0;
      commitVal_q   <= '0;
      commitReg_q   <= 1'b0;
      commitStore_q <= 1'b0;
      predictFail_q <= 1'b0;
      failAddr_q    <= '0;
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      pred_q        <= pred_d;
      type_q        <= type_d;
      rd_q          <= rd_d;
      val_q         <= val_d;
      addr_q        <= addr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commitValid_q <= commitValid_d;
      commitTag_q   <= commitTag_d;
      commitRd_q    <= commitRd_d;
      commitVal_q   <= commitVal_d;
      commitReg_q   <= commitReg_d;
      commitStore_q <= commitStore_d;
      predictFail_q <= predictFail_d;
      failAddr_q    <= failAddr_d;
    end
  end

  // Lookups read stored state; the bypass build also forwards a matching broadcast.
  always_comb begin
    query1_ready = busy_q[query1_tag] && ready_q[query1_tag];
    query1_val   = query1_ready ? val_q[query1_tag] : 32'd0;
    query2_ready = busy_q[query2_tag] && ready_q[query2_tag];
    query2_val   = query2_ready ? val_q[query2_tag] : 32'd0;
`ifdef ROB_QUERY_BYPASS_EN
    if (cdb_active && (cdb_tag == query1_tag) && busy_q[query1_tag]) begin
      query1_ready = 1'b1;
      query1_val   = cdb_val;
    end
    if (cdb_active && (cdb_tag == query2_tag) && busy_q[query2_tag]) begin
      query2_ready = 1'b1;
      query2_val   = cdb_val;
    end
`endif
  end

endmodule
